layer_compositor: RTL

LAYER_COMPOSITOR -- requirements
Module: layer_compositor

---
 rtl/layer_compositor.sv | 129 ++++++++++++
 1 files changed

// File: rtl/layer_compositor.sv
// Per-pixel layer compositor: folds a stream of sprite samples into one pixel,
// then emits the composited colour when a z == 0 background sample closes it.
module layer_compositor #(
    parameter int                 MY_X      = 0,
    parameter int                 MY_Y      = 0,
    parameter int                 TILE_LOG2 = 4,
    parameter int                 COLOR_W   = 8,
    parameter int                 Z_W       = 8,
    parameter logic [COLOR_W-1:0] KEY       = '1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              i_valid,
    output logic                              o_in_ready,
    input  logic [(1<<TILE_LOG2)*COLOR_W-1:0] i_texture_data,
    input  logic [TILE_LOG2:0]                i_start_x,
    input  logic [TILE_LOG2:0]                i_start_y,
    input  logic [Z_W-1:0]                    i_position_z,
    input  logic                              i_mode,
    output logic                              o_valid,
    input  logic                              i_out_ready,
    output logic [COLOR_W-1:0]                o_color,
    output logic [Z_W-1:0]                    o_depth,
    output logic [3:0]                        o_layers
);

    localparam int T = 1 << TILE_LOG2;
    localparam logic [TILE_LOG2-1:0] MX = MY_X[TILE_LOG2-1:0];
    localparam logic [TILE_LOG2-1:0] MY = MY_Y[TILE_LOG2-1:0];

    logic                 hit_q, hit_d;
    logic [COLOR_W-1:0]   acc_color_q, acc_color_d;
    logic [Z_W-1:0]       acc_z_q, acc_z_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 o_valid_q, o_valid_d;
    logic [COLOR_W-1:0]   o_color_q, o_color_d;
    logic [Z_W-1:0]       o_depth_q, o_depth_d;
    logic [3:0]           o_layers_q, o_layers_d;

    logic [TILE_LOG2:0]   dx, dy;
    logic                 in_win;
    logic [COLOR_W-1:0]   texels [T];
    logic [COLOR_W-1:0]   texel;
    logic                 opaque;
    logic                 accept;
    logic                 close_px;
    logic                 add_layer;
    logic                 takes_over;

    for (genvar k = 0; k < T; k++) begin : g_texel
        assign texels[k] = i_texture_data[k*COLOR_W +: COLOR_W];
    end

    // The prepended 1 absorbs the borrow: it survives (top bit set) exactly when
    // the sprite origin is at or before this pixel, and the low bits give the
    // texel offset into the sprite row.
    assign dx     = {1'b1, MX} - i_start_x;
    assign dy     = {1'b1, MY} - i_start_y;
    assign in_win = dx[TILE_LOG2] && dy[TILE_LOG2];
    assign texel  = texels[dx[TILE_LOG2-1:0]];
    assign opaque = (texel != KEY);

    assign o_in_ready = !o_valid_q || i_out_ready;
    assign accept     = i_valid && o_in_ready;
    assign close_px   = accept && (i_position_z == '0);
    assign add_layer  = accept && (i_position_z != '0) && in_win && opaque;
    assign takes_over = !hit_q || (i_position_z > acc_z_q) ||
                        ((i_position_z == acc_z_q) && !i_mode);

    always_comb begin
        hit_d       = hit_q;
        acc_color_d = acc_color_q;
        acc_z_d     = acc_z_q;
        cnt_d       = cnt_q;
        o_valid_d   = o_valid_q;
        o_color_d   = o_color_q;
        o_depth_d   = o_depth_q;
        o_layers_d  = o_layers_q;

        if (o_valid_q && i_out_ready) begin
            o_valid_d = 1'b0;
        end

        if (close_px) begin
            o_valid_d  = 1'b1;
            o_color_d  = hit_q ? acc_color_q : texel;
            o_depth_d  = hit_q ? acc_z_q : '0;
            o_layers_d = cnt_q;
            hit_d      = 1'b0;
            acc_z_d    = '0;
            cnt_d      = 4'd0;
        end else if (add_layer) begin
            cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
            if (takes_over) begin
                hit_d       = 1'b1;
                acc_color_d = texel;
                acc_z_d     = i_position_z;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_q       <= 1'b0;
            acc_color_q <= KEY;
            acc_z_q     <= '0;
            cnt_q       <= 4'd0;
            o_valid_q   <= 1'b0;
            o_color_q   <= KEY;
            o_depth_q   <= '0;
            o_layers_q  <= 4'd0;
        end else begin
            hit_q       <= hit_d;
            acc_color_q <= acc_color_d;
            acc_z_q     <= acc_z_d;
            cnt_q       <= cnt_d;
            o_valid_q   <= o_valid_d;
            o_color_q   <= o_color_d;
            o_depth_q   <= o_depth_d;
            o_layers_q  <= o_layers_d;
        end
    end

    assign o_valid  = o_valid_q;
    assign o_color  = o_color_q;
    assign o_depth  = o_depth_q;
    assign o_layers = o_layers_q;

endmodule
